rx_rst_sequencer: RTL and testbench

Reset sequencer for the OFDM receiver. It holds every RX sub-block in reset until the clock source has been locked for a programmable time. It then releases the sub-blocks one stage at a time in a fixed order, and on request runs a soft-reset cycle that re-asserts and re-releases all stages.

---
 rtl/rx_rst_sequencer.sv | 117 +++++++++++
 tb/tb_rx_rst_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_rst_sequencer.sv
// rtl/rx_rst_sequencer.sv - staged RX reset sequencer: lock hold, ordered release, soft-reset cycle
// Optional: RX_RST_LOCK_MON_EN monitors lock after HOLD and falls back to HOLD on loss of lock.
module rx_rst_sequencer #(
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGES      = 4,
    parameter int STAGE_GAP   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lock,
    input  logic              soft_req,
    output logic              soft_ack,
    output logic [STAGES-1:0] stage_rst,
    output logic              ready
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam int SW = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        RUN   = 2'd2,
        SOFT  = 2'd3
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [SW-1:0]   stage_idx;
    logic            lock_lost;

    always_comb begin
        lock_lost = 1'b0;
`ifdef RX_RST_LOCK_MON_EN
        lock_lost = (state != HOLD) && !lock;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            stage_idx <= '0;
            stage_rst <= '1;
            ready     <= 1'b0;
            soft_ack  <= 1'b0;
        end else begin
            soft_ack <= 1'b0;
            if (lock_lost) begin
                // Loss of lock outranks a pending soft request, so no ack here.
                state     <= HOLD;
                hold_cnt  <= '0;
                gap_cnt   <= '0;
                stage_idx <= '0;
                stage_rst <= '1;
                ready     <= 1'b0;
            end else begin
                case (state)
                    HOLD: begin
                        stage_rst <= '1;
                        ready     <= 1'b0;
                        if (!lock) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                            state     <= STAGE;
                            hold_cnt  <= '0;
                            gap_cnt   <= '0;
                            stage_idx <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    STAGE: begin
                        if (gap_cnt == GW'(STAGE_GAP - 1)) begin
                            gap_cnt   <= '0;
                            stage_idx <= stage_idx + 1'b1;
                            for (int i = 0; i < STAGES; i++) begin
                                if (SW'(i) == stage_idx) stage_rst[i] <= 1'b0;
                            end
                            if (stage_idx == SW'(STAGES - 1)) begin
                                state <= RUN;
                                ready <= 1'b1;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (soft_req) begin
                            state     <= SOFT;
                            stage_rst <= '1;
                            ready     <= 1'b0;
                            soft_ack  <= 1'b1;
                            gap_cnt   <= '0;
                            stage_idx <= '0;
                        end
                    end
                    SOFT: begin
                        stage_rst <= '1;
                        if (gap_cnt == GW'(STAGE_GAP - 1)) begin
                            state     <= STAGE;
                            gap_cnt   <= '0;
                            stage_idx <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= HOLD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_rst_sequencer.sv
// tb/tb_rx_rst_sequencer.sv - scoreboard bench for rx_rst_sequencer (default parameters)
module tb_rx_rst_sequencer;

    localparam int H = 1024;
    localparam int S = 4;
    localparam int G = 16;

    typedef struct packed {
        int         at;
        logic [3:0] sr;
        logic       rdy;
        logic       ack;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       soft_req = 1'b0;
    logic       soft_ack;
    logic [3:0] stage_rst;
    logic       ready;

    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_n = 0;
    logic [5:0] prev = 6'b111100;
    ev_t  expq[$];
    ev_t  obsq[$];

    rx_rst_sequencer #(.HOLD_CYCLES(H), .STAGES(S), .STAGE_GAP(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .lock      (lock),
        .soft_req  (soft_req),
        .soft_ack  (soft_ack),
        .stage_rst (stage_rst),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // Monitor: records every change of the output vector, tagged with its edge number.
    always @(posedge clk) begin
        #1;
        edge_n = edge_n + 1;
        if ({stage_rst, ready, soft_ack} !== prev) begin
            obsq.push_back('{edge_n, stage_rst, ready, soft_ack});
            prev = {stage_rst, ready, soft_ack};
        end
    end

    task automatic run_to(input int target);
        while (edge_n < target) @(negedge clk);
    endtask

    task automatic start_seq();
        rst = 1'b0;
        lock = 1'b0;
        soft_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        lock = 1'b1;
        edge_n = 0;
        prev = 6'b111100;
        obsq.delete();
        expq.delete();
    endtask

    task automatic push_release(input int base);
        logic [3:0] sr;
        for (int k = 0; k < S; k++) begin
            sr = 4'b1111 << (k + 1);
            expq.push_back('{base + (k + 1) * G, sr, (k == S - 1), 1'b0});
        end
    endtask

    task automatic push_soft(input int e);
        expq.push_back('{e, 4'b1111, 1'b0, 1'b1});
        expq.push_back('{e + 1, 4'b1111, 1'b0, 1'b0});
        push_release(e + G);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (stage_rst !== 4'b1111) begin n_err++; $display("FAIL reset_stage_rst got=%b exp=1111", stage_rst); end
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_cmp++;
        if (soft_ack !== 1'b0) begin n_err++; $display("FAIL reset_soft_ack got=%b exp=0", soft_ack); end
    endtask

    task automatic test_power_on();
        ev_t e, o;
        start_seq();
        push_release(H);
        run_to(H + S * G + 10);
        while (expq.size() > 0 || obsq.size() > 0) begin
            n_cmp++;
            if (expq.size() == 0) begin o = obsq.pop_front(); n_err++; $display("FAIL power_on extra edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack); end
            else if (obsq.size() == 0) begin e = expq.pop_front(); n_err++; $display("FAIL power_on missing edge=%0d sr=%b rdy=%b ack=%b", e.at, e.sr, e.rdy, e.ack); end
            else begin
                e = expq.pop_front(); o = obsq.pop_front();
                if (o !== e) begin n_err++; $display("FAIL power_on got edge=%0d sr=%b rdy=%b ack=%b exp edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack, e.at, e.sr, e.rdy, e.ack); end
            end
        end
    endtask

    task automatic test_soft_reset();
        ev_t e, o;
        int  ev;
        obsq.delete();
        ev = edge_n + 5;
        push_soft(ev);
        run_to(ev - 1);
        soft_req = 1'b1;
        run_to(ev);
        soft_req = 1'b0;
        run_to(ev + (S + 1) * G + 10);
        while (expq.size() > 0 || obsq.size() > 0) begin
            n_cmp++;
            if (expq.size() == 0) begin o = obsq.pop_front(); n_err++; $display("FAIL soft_reset extra edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack); end
            else if (obsq.size() == 0) begin e = expq.pop_front(); n_err++; $display("FAIL soft_reset missing edge=%0d sr=%b rdy=%b ack=%b", e.at, e.sr, e.rdy, e.ack); end
            else begin
                e = expq.pop_front(); o = obsq.pop_front();
                if (o !== e) begin n_err++; $display("FAIL soft_reset got edge=%0d sr=%b rdy=%b ack=%b exp edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack, e.at, e.sr, e.rdy, e.ack); end
            end
        end
    endtask

    task automatic test_lock_soft_same_cycle();
        ev_t e, o;
        int  ev;
        obsq.delete();
        ev = edge_n + 5;
`ifdef RX_RST_LOCK_MON_EN
        expq.push_back('{ev, 4'b1111, 1'b0, 1'b0});
        push_release(ev + H);
`else
        push_soft(ev);
`endif
        run_to(ev - 1);
        lock = 1'b0;
        soft_req = 1'b1;
        run_to(ev);
        lock = 1'b1;
        soft_req = 1'b0;
`ifdef RX_RST_LOCK_MON_EN
        run_to(ev + H + S * G + 10);
`else
        run_to(ev + (S + 1) * G + 10);
`endif
        while (expq.size() > 0 || obsq.size() > 0) begin
            n_cmp++;
            if (expq.size() == 0) begin o = obsq.pop_front(); n_err++; $display("FAIL lock_soft extra edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack); end
            else if (obsq.size() == 0) begin e = expq.pop_front(); n_err++; $display("FAIL lock_soft missing edge=%0d sr=%b rdy=%b ack=%b", e.at, e.sr, e.rdy, e.ack); end
            else begin
                e = expq.pop_front(); o = obsq.pop_front();
                if (o !== e) begin n_err++; $display("FAIL lock_soft got edge=%0d sr=%b rdy=%b ack=%b exp edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack, e.at, e.sr, e.rdy, e.ack); end
            end
        end
    endtask

    task automatic test_lock_glitch();
        ev_t e, o;
        start_seq();
        push_release(500 + H);
        run_to(499);
        lock = 1'b0;
        run_to(500);
        lock = 1'b1;
        run_to(500 + H + S * G + 10);
        while (expq.size() > 0 || obsq.size() > 0) begin
            n_cmp++;
            if (expq.size() == 0) begin o = obsq.pop_front(); n_err++; $display("FAIL lock_glitch extra edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack); end
            else if (obsq.size() == 0) begin e = expq.pop_front(); n_err++; $display("FAIL lock_glitch missing edge=%0d sr=%b rdy=%b ack=%b", e.at, e.sr, e.rdy, e.ack); end
            else begin
                e = expq.pop_front(); o = obsq.pop_front();
                if (o !== e) begin n_err++; $display("FAIL lock_glitch got edge=%0d sr=%b rdy=%b ack=%b exp edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack, e.at, e.sr, e.rdy, e.ack); end
            end
        end
    endtask

    task automatic test_soft_outside_run();
        ev_t e, o;
        start_seq();
        push_release(H);
        run_to(99);
        soft_req = 1'b1;
        run_to(109);
        soft_req = 1'b0;
        run_to(H + S * G + 10);
        while (expq.size() > 0 || obsq.size() > 0) begin
            n_cmp++;
            if (expq.size() == 0) begin o = obsq.pop_front(); n_err++; $display("FAIL soft_outside extra edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack); end
            else if (obsq.size() == 0) begin e = expq.pop_front(); n_err++; $display("FAIL soft_outside missing edge=%0d sr=%b rdy=%b ack=%b", e.at, e.sr, e.rdy, e.ack); end
            else begin
                e = expq.pop_front(); o = obsq.pop_front();
                if (o !== e) begin n_err++; $display("FAIL soft_outside got edge=%0d sr=%b rdy=%b ack=%b exp edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack, e.at, e.sr, e.rdy, e.ack); end
            end
        end
    endtask

    task automatic test_async_reset();
        ev_t e, o;
        start_seq();
        expq.push_back('{H + G, 4'b1110, 1'b0, 1'b0});
        expq.push_back('{H + 2 * G, 4'b1100, 1'b0, 1'b0});
        run_to(H + 2 * G + 4);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (stage_rst !== 4'b1111) begin n_err++; $display("FAIL async_rst_stage_rst got=%b exp=1111", stage_rst); end
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL async_rst_ready got=%b exp=0", ready); end
        prev = 6'b111100;
        @(negedge clk);
        rst = 1'b1;
        edge_n = 0;
        push_release(H);
        run_to(H + S * G + 10);
        while (expq.size() > 0 || obsq.size() > 0) begin
            n_cmp++;
            if (expq.size() == 0) begin o = obsq.pop_front(); n_err++; $display("FAIL async_rst extra edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack); end
            else if (obsq.size() == 0) begin e = expq.pop_front(); n_err++; $display("FAIL async_rst missing edge=%0d sr=%b rdy=%b ack=%b", e.at, e.sr, e.rdy, e.ack); end
            else begin
                e = expq.pop_front(); o = obsq.pop_front();
                if (o !== e) begin n_err++; $display("FAIL async_rst got edge=%0d sr=%b rdy=%b ack=%b exp edge=%0d sr=%b rdy=%b ack=%b", o.at, o.sr, o.rdy, o.ack, e.at, e.sr, e.rdy, e.ack); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_soft_reset();
        test_lock_soft_same_cycle();
        test_lock_glitch();
        test_soft_outside_run();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
